// File: rtl/vga_sync_generator_pkg.sv
// Shared raster constants for the 640x480@60 timing.
// Colour stage and sync generator both import these.
package vga_sync_generator_pkg;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL =
    H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL =
    V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam int CW = 10;

  typedef logic [CW-1:0] cnt_t;

  // lo <= c < hi, evaluated at counter width
  function automatic logic in_win(
    input cnt_t c,
    input int   lo,
    input int   hi
  );
    return (c >= cnt_t'(lo)) && (c < cnt_t'(hi));
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-MOD position counter with enable and wrap pulse.
// Used for both raster axes; h wrap enables v.
module vga_axis_counter
  import vga_sync_generator_pkg::*;
#(
  parameter int MOD = 800
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          wrap
);

  assign wrap = en && (count == cnt_t'(MOD - 1));

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else if (en) begin
      count <= count + cnt_t'(1);
    end
  end

endmodule

// File: rtl/vga_sync_generator.sv
// VGA raster counters, display enable, ticks and
// sync outputs delayed to match the colour path.
module vga_sync_generator
  import vga_sync_generator_pkg::*;
#(
  parameter int H_DISPLAY  = vga_sync_generator_pkg::H_DISPLAY,
  parameter int H_FRONT    = vga_sync_generator_pkg::H_FRONT,
  parameter int H_SYNC     = vga_sync_generator_pkg::H_SYNC,
  parameter int H_BACK     = vga_sync_generator_pkg::H_BACK,
  parameter int V_DISPLAY  = vga_sync_generator_pkg::V_DISPLAY,
  parameter int V_FRONT    = vga_sync_generator_pkg::V_FRONT,
  parameter int V_SYNC     = vga_sync_generator_pkg::V_SYNC,
  parameter int V_BACK     = vga_sync_generator_pkg::V_BACK,
  parameter int PIPE_DELAY = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       display_en,
  output logic       VGA_HSYNC,
  output logic       VGA_VSYNC,
  output logic       frame_tick,
  output logic       line_tick
);

  localparam int HT =
    H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int VT =
    V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_LO = H_DISPLAY + H_FRONT;
  localparam int HS_HI = HS_LO + H_SYNC;
  localparam int VS_LO = V_DISPLAY + V_FRONT;
  localparam int VS_HI = VS_LO + V_SYNC;

  if (HT - 1 >= 1024 || VT - 1 >= 1024) begin : g_bad_total
    $error("raster totals exceed 10-bit counters");
  end

  if (PIPE_DELAY < 0 || PIPE_DELAY > 3) begin : g_bad_delay
    $error("PIPE_DELAY must be 0..3");
  end

  logic h_wrap;
  logic v_wrap;
  logic hs_raw;
  logic vs_raw;
  logic in_rst;

  vga_axis_counter #(
    .MOD (HT)
  ) u_h (
    .CLK   (CLK),
    .RST_N (RST_N),
    .en    (1'b1),
    .count (h_count),
    .wrap  (h_wrap)
  );

  vga_axis_counter #(
    .MOD (VT)
  ) u_v (
    .CLK   (CLK),
    .RST_N (RST_N),
    .en    (h_wrap),
    .count (v_count),
    .wrap  (v_wrap)
  );

  // Ticks stay quiet while the raster is parked in reset
  always_ff @(posedge CLK) begin
    in_rst <= !RST_N;
  end

  assign display_en =
    (h_count < cnt_t'(H_DISPLAY)) &&
    (v_count < cnt_t'(V_DISPLAY));

  assign hs_raw = !in_win(h_count, HS_LO, HS_HI);
  assign vs_raw = !in_win(v_count, VS_LO, VS_HI);

  assign line_tick = !in_rst && (h_count == '0);
  assign frame_tick =
    !in_rst && (h_count == '0) &&
    (v_count == cnt_t'(V_DISPLAY));

  if (PIPE_DELAY == 0) begin : g_direct
    assign VGA_HSYNC = hs_raw;
    assign VGA_VSYNC = vs_raw;
  end else begin : g_pipe
    logic [PIPE_DELAY-1:0] hs_q;
    logic [PIPE_DELAY-1:0] vs_q;

    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        hs_q <= '1;
        vs_q <= '1;
      end else begin
        hs_q[0] <= hs_raw;
        vs_q[0] <= vs_raw;
        for (int i = 1; i < PIPE_DELAY; i++) begin
          hs_q[i] <= hs_q[i-1];
          vs_q[i] <= vs_q[i-1];
        end
      end
    end

    assign VGA_HSYNC = hs_q[PIPE_DELAY-1];
    assign VGA_VSYNC = vs_q[PIPE_DELAY-1];
  end

  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench: full-size raster plus a shrunken raster at
// PIPE_DELAY 1 and 0, checked against a position model.
module tb_vga_sync_generator;

  localparam int SH_D = 20;
  localparam int SH_F = 3;
  localparam int SH_S = 5;
  localparam int SH_B = 4;
  localparam int SV_D = 10;
  localparam int SV_F = 2;
  localparam int SV_S = 2;
  localparam int SV_B = 3;
  localparam int SHT  = SH_D + SH_F + SH_S + SH_B;
  localparam int SVT  = SV_D + SV_F + SV_S + SV_B;
  localparam int FRF  = 800 * 525;
  localparam int FRS  = SHT * SVT;

  logic CLK;
  logic RST_N;

  logic [9:0] f_h, f_v, a_h, a_v, b_h, b_v;
  logic f_de, f_hs, f_vs, f_ft, f_lt;
  logic a_de, a_hs, a_vs, a_ft, a_lt;
  logic b_de, b_hs, b_vs, b_ft, b_lt;

  int n_chk  = 0;
  int n_fail = 0;

  vga_sync_generator u_full (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .h_count    (f_h),
    .v_count    (f_v),
    .display_en (f_de),
    .VGA_HSYNC  (f_hs),
    .VGA_VSYNC  (f_vs),
    .frame_tick (f_ft),
    .line_tick  (f_lt)
  );

  vga_sync_generator #(
    .H_DISPLAY (SH_D), .H_FRONT (SH_F),
    .H_SYNC    (SH_S), .H_BACK  (SH_B),
    .V_DISPLAY (SV_D), .V_FRONT (SV_F),
    .V_SYNC    (SV_S), .V_BACK  (SV_B),
    .PIPE_DELAY (1)
  ) u_s1 (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .h_count    (a_h),
    .v_count    (a_v),
    .display_en (a_de),
    .VGA_HSYNC  (a_hs),
    .VGA_VSYNC  (a_vs),
    .frame_tick (a_ft),
    .line_tick  (a_lt)
  );

  vga_sync_generator #(
    .H_DISPLAY (SH_D), .H_FRONT (SH_F),
    .H_SYNC    (SH_S), .H_BACK  (SH_B),
    .V_DISPLAY (SV_D), .V_FRONT (SV_F),
    .V_SYNC    (SV_S), .V_BACK  (SV_B),
    .PIPE_DELAY (0)
  ) u_s0 (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .h_count    (b_h),
    .v_count    (b_v),
    .display_en (b_de),
    .VGA_HSYNC  (b_hs),
    .VGA_VSYNC  (b_vs),
    .frame_tick (b_ft),
    .line_tick  (b_lt)
  );

  initial CLK = 1'b0;
  always #20 CLK = ~CLK;

  // Model: linear position within the frame
  int pf = 0;
  int ps = 0;
  int k  = 0;
  bit m_rst = 1'b1;
  bit m_ok  = 1'b0;

  always @(posedge CLK) begin
    if (!RST_N) begin
      pf <= 0;
      ps <= 0;
      k <= 0;
      m_rst <= 1'b1;
      m_ok <= 1'b1;
    end else if (m_ok) begin
      pf <= (pf + 1) % FRF;
      ps <= (ps + 1) % FRS;
      k <= k + 1;
      m_rst <= 1'b0;
    end
  end

  function automatic bit outside(int x, int lo, int n);
    return !(x >= lo && x < lo + n);
  endfunction

  function automatic logic [24:0] expv(
    input int p, input int kk, input bit r,
    input int hd, input int hf, input int hs, input int hb,
    input int vd, input int vf, input int vs, input int vb,
    input int pd
  );
    int ht, fr, h, v, q, qh, qv;
    bit de, lt, ft, hsy, vsy;
    ht = hd + hf + hs + hb;
    fr = ht * (vd + vf + vs + vb);
    h = p % ht;
    v = p / ht;
    q = (p + fr - 1) % fr;
    qh = q % ht;
    qv = q / ht;
    de = (h < hd) && (v < vd);
    lt = !r && (h == 0);
    ft = !r && (h == 0) && (v == vd);
    if (pd == 0) begin
      hsy = outside(h, hd + hf, hs);
      vsy = outside(v, vd + vf, vs);
    end else if (kk == 0) begin
      hsy = 1'b1;
      vsy = 1'b1;
    end else begin
      hsy = outside(qh, hd + hf, hs);
      vsy = outside(qv, vd + vf, vs);
    end
    return {10'(h), 10'(v), de, lt, ft, hsy, vsy};
  endfunction

  task automatic cmp_vec(
    input string nm,
    input logic [24:0] act,
    input logic [24:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got h=%0d v=%0d flags=%b, want h=%0d v=%0d flags=%b",
        nm, $time, act[24:15], act[14:5], act[4:0],
        exp[24:15], exp[14:5], exp[4:0]);
    end
  endtask

  always @(negedge CLK) begin
    if (m_ok) begin
      cmp_vec("full", {f_h, f_v, f_de, f_lt, f_ft, f_hs, f_vs},
        expv(pf, k, m_rst, 640, 16, 96, 48, 480, 10, 2, 33, 1));
      cmp_vec("small_pd1", {a_h, a_v, a_de, a_lt, a_ft, a_hs, a_vs},
        expv(ps, k, m_rst, SH_D, SH_F, SH_S, SH_B,
             SV_D, SV_F, SV_S, SV_B, 1));
      cmp_vec("small_pd0", {b_h, b_v, b_de, b_lt, b_ft, b_hs, b_vs},
        expv(ps, k, m_rst, SH_D, SH_F, SH_S, SH_B,
             SV_D, SV_F, SV_S, SV_B, 0));
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, want %0d", nm, $time, act, exp);
    end
  endtask

  initial begin
    int cnt, first_lo, rise, lo_n, de0, prev;
    int ticks, last_t, first_t, cyc, run, in_run;

    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_h", f_h, 0);
    chk("rst_v", f_v, 0);
    chk("rst_hs", f_hs, 1);
    chk("rst_vs", f_vs, 1);
    chk("rst_ft", f_ft, 0);
    chk("rst_lt", f_lt, 0);
    chk("rst_de", f_de, 1);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("rel_h1", f_h, 1);

    cnt = 0;
    while (!(f_h == 799 && f_v == 10) && cnt < 10000) begin
      @(negedge CLK);
      cnt++;
    end
    chk("wait_799_10", int'(f_h == 799 && f_v == 10), 1);
    @(negedge CLK);
    chk("wrap_h", f_h, 0);
    chk("wrap_v", f_v, 11);
    chk("wrap_lt", f_lt, 1);
    @(negedge CLK);
    chk("lt_one_cycle", f_lt, 0);

    first_lo = -1;
    rise = -1;
    lo_n = 0;
    de0 = 0;
    prev = f_hs;
    repeat (799) begin
      @(negedge CLK);
      if (prev == 1 && f_hs == 0) first_lo = f_h;
      if (prev == 0 && f_hs == 1) rise = f_h;
      lo_n += int'(!f_hs);
      de0 += int'(!f_de);
      prev = f_hs;
    end
    chk("hs_first_low_h", first_lo, 657);
    chk("hs_rise_h", rise, 753);
    chk("hs_width", lo_n, 96);
    chk("de_blank_count", de0, 160);

    cnt = 0;
    while (f_h != 300 && cnt < 1000) begin
      @(negedge CLK);
      cnt++;
    end
    chk("wait_h300", f_h, 300);
    RST_N = 1'b0;
    @(negedge CLK);
    chk("mid_rst_h", f_h, 0);
    chk("mid_rst_v", f_v, 0);
    chk("mid_rst_hs", f_hs, 1);
    chk("mid_rst_vs", f_vs, 1);
    chk("mid_rst_ft", f_ft, 0);
    repeat (4) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("mid_rel_h1", f_h, 1);

    ticks = 0;
    last_t = -1;
    first_t = -1;
    run = 0;
    in_run = 0;
    prev = a_vs;
    for (cyc = 0; cyc < 1700; cyc++) begin
      @(negedge CLK);
      if (a_ft) begin
        chk("ft_pos_h", a_h, 0);
        chk("ft_pos_v", a_v, SV_D);
        if (last_t >= 0) chk("ft_interval", cyc - last_t, FRS);
        if (first_t < 0) first_t = cyc;
        last_t = cyc;
        ticks++;
      end
      if (prev == 1 && a_vs == 0) begin
        chk("vs_start_h", a_h, 1);
        chk("vs_start_v", a_v, SV_D + SV_F);
        in_run = 1;
        run = 0;
      end
      if (in_run && a_vs == 0) run++;
      if (in_run && prev == 0 && a_vs == 1) begin
        chk("vs_width", run, 64);
        in_run = 0;
      end
      prev = a_vs;
    end
    chk("ft_count", ticks, 3);
    chk("ft_span_3frames", last_t - first_t, 1088);

    cnt = 0;
    while (!(a_h == 31 && a_v == 16) && cnt < 600) begin
      @(negedge CLK);
      cnt++;
    end
    chk("wait_frame_end", int'(a_h == 31 && a_v == 16), 1);
    @(negedge CLK);
    chk("fwrap_h", a_h, 0);
    chk("fwrap_v", a_v, 0);
    chk("fwrap_de", a_de, 1);
    chk("fwrap_ft", a_ft, 0);

    cnt = 0;
    while (b_h != 22 && cnt < 100) begin
      @(negedge CLK);
      cnt++;
    end
    chk("wait_pd0_h22", b_h, 22);
    chk("pd0_hs_pre", b_hs, 1);
    @(negedge CLK);
    chk("pd0_h23", b_h, 23);
    chk("pd0_hs_same_cycle", b_hs, 0);
    chk("pd1_hs_lags", a_hs, 1);
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    chk("pd0_rst_in_sync_hs", b_hs, 1);
    chk("pd0_rst_h", b_h, 0);
    chk("pd0_rst_lt", b_lt, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (4) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
